// File: rtl/imi_wr_sched_pkg.sv
// Shared types and helpers for the imitator write scheduler.
package imi_wr_sched_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StPlay = 1'b1
    } state_e;

    // Queue entry layout: {last, addr, data}.
    function automatic int unsigned entry_width(input int unsigned aw, input int unsigned dw);
        return 1 + aw + dw;
    endfunction

endpackage

// File: rtl/imi_sched_fifo.sv
// Synchronous FIFO holding queued imitator writes; head is visible combinationally on rdata.
module imi_sched_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 49
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        rdata    = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/imi_wr_sched.sv
// Epoch-aligned imitator register-port scheduler: replays queued write batches on trig and
// slots direct host reads/writes into idle port cycles.
module imi_wr_sched
    import imi_wr_sched_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  cmd_last,
    input  logic                  trig,
    input  logic                  host_wr,
    input  logic                  host_rd,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_rvalid,
    output logic                  host_wait,
    output logic                  imi_wr_en,
    output logic                  imi_rd_en,
    output logic [ADDR_WIDTH-1:0] imi_reg_addr,
    output logic [DATA_WIDTH-1:0] imi_wdata,
    input  logic [DATA_WIDTH-1:0] imi_rdata,
    output logic                  batch_done,
    output logic                  underrun,
    output logic                  overrun,
    input  logic                  err_clr
);

    localparam int unsigned EW  = entry_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int unsigned NBW = $clog2(DEPTH) + 1;

    state_e                state_q, state_d;
    logic [NBW-1:0]        nbatch_q, nbatch_d;
    logic                  slot_valid_q, slot_valid_d;
    logic                  slot_wr_q, slot_wr_d;
    logic [ADDR_WIDTH-1:0] slot_addr_q, slot_addr_d;
    logic [DATA_WIDTH-1:0] slot_data_q, slot_data_d;
    logic                  from_slot_q, from_slot_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  batch_done_q, batch_done_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  underrun_q, underrun_d;
    logic                  overrun_q, overrun_d;

    logic [EW-1:0] head;
    logic          fifo_full, fifo_empty;
    logic          push, pop, start, head_last, host_req;

    imi_sched_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({cmd_last, cmd_addr, cmd_data}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        push      = cmd_valid & ~fifo_full;
        head_last = head[EW-1];
        start     = (state_q == StIdle) && trig && (nbatch_q != '0);
        pop       = ((state_q == StPlay) || start) && !fifo_empty;
        host_wait = slot_valid_q | from_slot_q;
        // A host strobe is dropped while an earlier one is still waiting or being issued.
        host_req  = (host_wr | host_rd) & ~host_wait;

        state_d      = state_q;
        slot_valid_d = slot_valid_q;
        slot_wr_d    = slot_wr_q;
        slot_addr_d  = slot_addr_q;
        slot_data_d  = slot_data_q;
        from_slot_d  = 1'b0;
        wr_en_d      = 1'b0;
        rd_en_d      = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        batch_done_d = 1'b0;

        if (pop) begin
            wr_en_d = 1'b1;
            addr_d  = head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
            wdata_d = head[DATA_WIDTH-1:0];
            if (head_last) begin
                batch_done_d = 1'b1;
                state_d      = StIdle;
            end else begin
                state_d = StPlay;
            end
            if (host_req) begin
                slot_valid_d = 1'b1;
                slot_wr_d    = host_wr;
                slot_addr_d  = host_addr;
                slot_data_d  = host_wdata;
            end
        end else if (slot_valid_q) begin
            wr_en_d      = slot_wr_q;
            rd_en_d      = ~slot_wr_q;
            addr_d       = slot_addr_q;
            wdata_d      = slot_wr_q ? slot_data_q : wdata_q;
            slot_valid_d = 1'b0;
            from_slot_d  = 1'b1;
        end else if (host_req) begin
            wr_en_d = host_wr;
            rd_en_d = ~host_wr;
            addr_d  = host_addr;
            wdata_d = host_wr ? host_wdata : wdata_q;
        end

        if (state_q == StPlay && fifo_empty) state_d = StIdle;

        nbatch_d = nbatch_q + NBW'(push & cmd_last) - NBW'(pop & head_last);

        rd_pend_d = rd_en_q;
        rvalid_d  = rd_pend_q;
        rdata_d   = rd_pend_q ? imi_rdata : rdata_q;

        underrun_d = (underrun_q & ~err_clr) | ((state_q == StIdle) && trig && nbatch_q == '0);
        overrun_d  = (overrun_q & ~err_clr) | ((state_q == StPlay) && trig);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            nbatch_q     <= '0;
            slot_valid_q <= 1'b0;
            slot_wr_q    <= 1'b0;
            slot_addr_q  <= '0;
            slot_data_q  <= '0;
            from_slot_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            batch_done_q <= 1'b0;
            rd_pend_q    <= 1'b0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            underrun_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            nbatch_q     <= nbatch_d;
            slot_valid_q <= slot_valid_d;
            slot_wr_q    <= slot_wr_d;
            slot_addr_q  <= slot_addr_d;
            slot_data_q  <= slot_data_d;
            from_slot_q  <= from_slot_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            batch_done_q <= batch_done_d;
            rd_pend_q    <= rd_pend_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            underrun_q   <= underrun_d;
            overrun_q    <= overrun_d;
        end
    end

    assign cmd_ready    = ~fifo_full;
    assign imi_wr_en    = wr_en_q;
    assign imi_rd_en    = rd_en_q;
    assign imi_reg_addr = addr_q;
    assign imi_wdata    = wdata_q;
    assign batch_done   = batch_done_q;
    assign host_rdata   = rdata_q;
    assign host_rvalid  = rvalid_q;
    assign underrun     = underrun_q;
    assign overrun      = overrun_q;

endmodule
